// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 32-bit MIPS core: captures decode, detects
// load-use hazards, and drives the EX-stage ALU through a two-source forward net.
module id_ex_stage #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         id_valid,
  input  logic [4:0]   id_rs,
  input  logic [4:0]   id_rt,
  input  logic [4:0]   id_rd,
  input  logic         id_uses_rs,
  input  logic         id_uses_rt,
  input  logic [W-1:0] id_rs_data,
  input  logic [W-1:0] id_rt_data,
  input  logic [W-1:0] id_imm,
  input  logic [4:0]   id_shamt,
  input  logic [3:0]   id_alu_op,
  input  logic         id_use_imm,
  input  logic         id_reg_write,
  input  logic         id_mem_read,
  input  logic         id_mem_write,
  input  logic         id_mem_to_reg,
  input  logic         exm_reg_write,
  input  logic [4:0]   exm_rd,
  input  logic [W-1:0] exm_result,
  input  logic         mwb_reg_write,
  input  logic [4:0]   mwb_rd,
  input  logic [W-1:0] mwb_result,
  input  logic         flush,
  output logic         stall,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [4:0]   shamt,
  output logic [3:0]   alu_op,
  output logic [W-1:0] ex_store_data,
  output logic         ex_valid,
  output logic [4:0]   ex_rd,
  output logic         ex_reg_write,
  output logic         ex_mem_read,
  output logic         ex_mem_write,
  output logic         ex_mem_to_reg
);

  localparam int unsigned RW = 5;
  localparam int unsigned OW = 4;

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] rd;
    logic [W-1:0]  rs_data;
    logic [W-1:0]  rt_data;
    logic [W-1:0]  imm;
    logic [RW-1:0] shamt;
    logic [OW-1:0] alu_op;
    logic          use_imm;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          mem_to_reg;
  } stage_t;

  stage_t        r_stage;
  stage_t        w_next;
  logic          w_hazard;
  logic          w_bubble;
  logic          w_load_in_ex;
  logic [W-1:0]  w_rs_capt;
  logic [W-1:0]  w_rt_capt;
  logic [W-1:0]  w_fwd_rs;
  logic [W-1:0]  w_fwd_rt;

  // Register $0 is hardwired, so a write to it never matches a reader.
  function automatic logic src_hit(input logic we, input logic [RW-1:0] wr_rd,
                                   input logic [RW-1:0] src);
    return we && (wr_rd != RW'(0)) && (wr_rd == src);
  endfunction

  // EX/MEM result is younger than MEM/WB, so it takes priority.
  function automatic logic [W-1:0] fwd_sel(input logic [RW-1:0] src,
                                           input logic [W-1:0]  dflt,
                                           input logic          ex_we,
                                           input logic [RW-1:0] ex_rd_i,
                                           input logic [W-1:0]  ex_res,
                                           input logic          wb_we,
                                           input logic [RW-1:0] wb_rd_i,
                                           input logic [W-1:0]  wb_res);
    if (src_hit(ex_we, ex_rd_i, src)) begin
      return ex_res;
    end
    if (src_hit(wb_we, wb_rd_i, src)) begin
      return wb_res;
    end
    return dflt;
  endfunction

  // Load-use detection against the instruction currently held in EX.
  always_comb begin
    w_hazard     = 1'b0;
    w_load_in_ex = r_stage.valid && r_stage.mem_read && (r_stage.rd != RW'(0));
    if (id_valid && w_load_in_ex) begin
      w_hazard = (id_uses_rs && (id_rs == r_stage.rd)) ||
                 (id_uses_rt && (id_rt == r_stage.rd));
    end
  end

  assign stall    = w_hazard && !flush;
  assign w_bubble = flush || !id_valid || w_hazard;

  // Register-file write-through: a same-cycle MEM/WB write beats the stale read.
  always_comb begin
    w_rs_capt = id_rs_data;
    w_rt_capt = id_rt_data;
    if (src_hit(mwb_reg_write, mwb_rd, id_rs)) begin
      w_rs_capt = mwb_result;
    end
    if (src_hit(mwb_reg_write, mwb_rd, id_rt)) begin
      w_rt_capt = mwb_result;
    end
  end

  always_comb begin
    w_next = '0;
    if (!w_bubble) begin
      w_next.valid      = 1'b1;
      w_next.rs         = id_rs;
      w_next.rt         = id_rt;
      w_next.rd         = id_rd;
      w_next.rs_data    = w_rs_capt;
      w_next.rt_data    = w_rt_capt;
      w_next.imm        = id_imm;
      w_next.shamt      = id_shamt;
      w_next.alu_op     = id_alu_op;
      w_next.use_imm    = id_use_imm;
      w_next.reg_write  = id_reg_write;
      w_next.mem_read   = id_mem_read;
      w_next.mem_write  = id_mem_write;
      w_next.mem_to_reg = id_mem_to_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage <= '0;
    end else begin
      r_stage <= w_next;
    end
  end

  always_comb begin
    w_fwd_rs = fwd_sel(r_stage.rs, r_stage.rs_data, exm_reg_write, exm_rd, exm_result,
                       mwb_reg_write, mwb_rd, mwb_result);
    w_fwd_rt = fwd_sel(r_stage.rt, r_stage.rt_data, exm_reg_write, exm_rd, exm_result,
                       mwb_reg_write, mwb_rd, mwb_result);
  end

  assign alu_a         = w_fwd_rs;
  assign alu_b         = r_stage.use_imm ? r_stage.imm : w_fwd_rt;
  assign ex_store_data = w_fwd_rt;
  assign shamt         = r_stage.shamt;
  assign alu_op        = r_stage.alu_op;
  assign ex_valid      = r_stage.valid;
  assign ex_rd         = r_stage.rd;
  assign ex_reg_write  = r_stage.reg_write;
  assign ex_mem_read   = r_stage.mem_read;
  assign ex_mem_write  = r_stage.mem_write;
  assign ex_mem_to_reg = r_stage.mem_to_reg;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage feeding the EX-stage ALU of the 32-bit MIPS core. Each cycle it latches the decoded instruction (operands, immediate, shift amount, ALU opcode, memory/writeback controls) from decode. It then drives the ALU's `alu_a`, `alu_b`, `shamt` and `alu_op` through a two-source forwarding network. It also detects load-use hazards, stalls decode, and inserts bubbles on stall or flush.

## Interface
- `W`, 32, datapath width.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_valid` in 1: decode presents a real instruction.
- `id_rs`, `id_rt`, `id_rd` in 5: source and destination register numbers; `id_rd` is the final write target.
- `id_uses_rs`, `id_uses_rt` in 1: instruction reads rs / rt.
- `id_rs_data`, `id_rt_data` in W: register-file read data.
- `id_imm` in W: already-extended immediate.
- `id_shamt` in 5, `id_alu_op` in 4, `id_use_imm` in 1: `id_use_imm` selects `id_imm` for `alu_b`.
- `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_mem_to_reg` in 1: controls.
- `exm_reg_write` in 1, `exm_rd` in 5, `exm_result` in W: EX/MEM forwarding source.
- `mwb_reg_write` in 1, `mwb_rd` in 5, `mwb_result` in W: MEM/WB forwarding source; also the register-file write port.
- `flush` in 1: squash the instruction entering from decode.
- `stall` out 1: hold PC and IF/ID this cycle.
- `alu_a`, `alu_b` out W; `shamt` out 5; `alu_op` out 4: ALU inputs.
- `ex_store_data` out W: forwarded rt value for stores.
- `ex_valid`, `ex_rd` (5), `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg` out: to EX/MEM.

## Operation
- Stage register fields: valid, rs, rt, rd, rs_data, rt_data, imm, shamt, alu_op, use_imm, and the four controls. All fields load every cycle; there is no hold.
- **Capture (no bubble):** all fields take their `id_*` values, with a write-through bypass on the data fields.
  - If `mwb_reg_write` is set, `mwb_rd != 0` and `mwb_rd == id_rs`, then rs_data captures `mwb_result`; otherwise it captures `id_rs_data`.
  - rt_data uses the same rule against `id_rt`.
- **Bubble:** a bubble is loaded when `flush`, `!id_valid`, or the internal hazard is set.
  - A bubble clears every field to 0: valid, all controls, rs/rt/rd, all data, alu_op.
- **Hazard:** set when `ex_valid & ex_mem_read & (ex_rd != 0)` and one of the following holds:
  - `id_uses_rs & (id_rs == ex_rd)`, or
  - `id_uses_rt & (id_rt == ex_rd)`.
  - The hazard is only evaluated when `id_valid` is set.
- `stall = hazard & ~flush`. When `flush` and hazard occur together, flush wins: a bubble is loaded and `stall` = 0.
- **Forwarding** (combinational from the stage register):
  - fwd_rs = `exm_result` if `exm_reg_write & exm_rd != 0 & exm_rd == rs`.
  - Otherwise fwd_rs = `mwb_result` if the same condition holds on mwb.
  - Otherwise fwd_rs = rs_data. EX/MEM has priority over MEM/WB. fwd_rt is built the same way.
  - Register 0 is never forwarded; its value is always 0.
- ALU outputs:
  - `alu_a` = fwd_rs. Variable shifts take their amount from `alu_a`.
  - `alu_b` = use_imm ? imm : fwd_rt.
  - `ex_store_data` = fwd_rt.
  - `shamt` and `alu_op` come straight from the stage register.
- All arithmetic is pass-through; the block does no width conversion.

## Timing
- Capture latency is 1 cycle: `id_*` sampled at edge N appear on the stage outputs after edge N.
- Forwarding and `stall` have zero latency; both are purely combinational.
- Reset (async assert, sync release):
  - All fields are 0.
  - Outputs: `alu_a` = `alu_b` = `ex_store_data` = 0, `shamt` = 0, `alu_op` = 0 (ADD), `ex_rd` = 0, `stall` = 0, and all `ex_*` controls = 0.
- Reset mid-stall: the stalled instruction is dropped, and `stall` falls with reset.
- A load-use pair costs exactly one bubble. On the next cycle the load has moved to EX/MEM, the hazard clears, and the value is forwarded from MEM/WB on the following cycle.
- Back-to-back dependent ALU ops need no stall: the result is forwarded from EX/MEM.

## Test plan
- **Reset:** assert `rst_n`=0 with random `id_*` values → all outputs 0 and `stall` = 0; after release, the first valid instruction appears after 1 edge.
- **EX/MEM forward:** issue `add $3,$1,$2` then `sub $4,$3,$5` with `exm_rd`=3, `exm_result`=0x0000_0010; also set `mwb_rd`=3, `mwb_result`=0x99 → `alu_a` = 0x10 (EX/MEM wins).
- **$0 guard:** set `exm_rd`=0, `exm_result`=0xFFFF_FFFF, `exm_reg_write`=1 for an instruction with rs=0 → `alu_a` = 0.
- **Load-use:** issue `lw $2,0($1)` then `add $4,$2,$2` → `stall` = 1 for exactly 1 cycle with a bubble (`ex_valid`=0); the add then executes with `alu_a` = `alu_b` = `mwb_result` (e.g. 0x1234).
- **Flush versus hazard:** present a load-use hazard with `flush`=1 → `stall` = 0 and `ex_valid` = 0 on the next cycle.
- **Write-through:** `id_rs`=7, `id_rs_data`=0x5, `mwb_rd`=7, `mwb_result`=0xA, `mwb_reg_write`=1 → the captured `alu_a` equals 0xA after the edge, even once mwb is idle.
